// File: rtl/bit_serial_alu.sv
// Bit-serial WIDTH-bit ALU: one 1-bit slice processed LSB->MSB, with start/done handshake and flags.
// Optional macro ALU_ABORT_EN adds an abort input that cancels an operation in RUN.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         ctl_q, ctl_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // 1-bit slice
  logic ai, bi, slice_sum, slice_cout, slice_res;
  logic cin_msb, sum_msb, ovf_raw, set_bit, last_bit;
  logic [WIDTH-1:0] res_word;

  always_comb begin
    ai         = a_q[idx_q] ^ ctl_q[3];
    bi         = b_q[idx_q] ^ ctl_q[2];
    slice_sum  = ai ^ bi ^ carry_q;
    slice_cout = (ai & bi) | (carry_q & (ai ^ bi));
    unique case (ctl_q[1:0])
      2'd0:    slice_res = ai & bi;
      2'd1:    slice_res = ai | bi;
      2'd2:    slice_res = slice_sum;
      default: slice_res = 1'b0;  // Less is tied low while bits are processed
    endcase
  end

  assign last_bit = (idx_q == CNT_W'(WIDTH - 1));
  assign cin_msb  = carry_q;
  assign sum_msb  = slice_sum;
  assign ovf_raw  = cin_msb ^ slice_cout;
  assign set_bit  = sum_msb ^ ovf_raw;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    res_word = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ctl_d   = alu_ctl;
          carry_d = alu_ctl[2];
          idx_d   = '0;
          sr_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
`ifdef ALU_ABORT_EN
        if (abort) begin
          state_d = StIdle;
        end else
`endif
        begin
          carry_d = slice_cout;
          sr_d    = {slice_res, sr_q[WIDTH-1:1]};
          if (last_bit) begin
            // Final bit: commit result and flags on the edge into FIN
            res_word = (ctl_q[1:0] == 2'd3) ? {{(WIDTH-1){1'b0}}, set_bit} : sr_d;
            result_d = res_word;
            zero_d   = (res_word == '0);
            cout_d   = slice_cout;
            ovf_d    = ctl_q[1] ? ovf_raw : 1'b0;
            state_d  = StFin;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed scoreboard bench for bit_serial_alu (WIDTH=8); abort test only when ALU_ABORT_EN is defined.
module tb_bit_serial_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a, b, result;
  logic         busy, done, zero, carry_out, overflow;
`ifdef ALU_ABORT_EN
  logic         abort;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_ctl   (alu_ctl),
    .a         (a),
    .b         (b),
`ifdef ALU_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: two's-complement arithmetic on the inverted operands
  function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t     e;
    logic [W-1:0] ai, bi;
    logic [W:0]   sum;
    logic [W-1:0] low;
    logic         cin_msb, ovf;
    ai      = av ^ {W{ctl[3]}};
    bi      = bv ^ {W{ctl[2]}};
    sum     = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ctl[2]};
    low     = {1'b0, ai[W-2:0]} + {1'b0, bi[W-2:0]} + {{(W-1){1'b0}}, ctl[2]};
    cin_msb = low[W-1];
    ovf     = cin_msb ^ sum[W];
    case (ctl[1:0])
      2'd0:    e.res = ai & bi;
      2'd1:    e.res = ai | bi;
      2'd2:    e.res = sum[W-1:0];
      default: e.res = {{(W-1){1'b0}}, sum[W-1] ^ ovf};
    endcase
    e.c = sum[W];
    e.v = ctl[1] ? ovf : 1'b0;
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // restart_at < 0: no extra start pulse during RUN
  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int restart_at);
    exp_t         e;
    int           n;
    bit           seen;
    logic [W-1:0] held;
    held    = last_res;
    alu_ctl = ctl;
    a       = av;
    b       = bv;
    start   = 1'b1;
    sb.push_back(model(ctl, av, bv));
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      if (n == restart_at) begin
        start   = 1'b1;
        alu_ctl = 4'b0001;
        a       = ~av;
        b       = ~bv;
      end
      tick();
      n++;
      start = 1'b0;
      if (n == 3) check({tag, "_hold"}, {24'b0, result}, {24'b0, held});
      if (done) seen = 1'b1;
    end
    // done is high in the cycle after edge E_WIDTH (the 9th cycle counting the start cycle)
    check({tag, "_latency"}, n, W);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    if (seen) begin
      check({tag, "_result"}, {24'b0, result}, {24'b0, e.res});
      check({tag, "_zero"}, {31'b0, zero}, {31'b0, e.z});
      check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, e.c});
      check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, e.v});
      check({tag, "_busy_fin"}, {31'b0, busy}, 32'd1);
      last_res = e.res;
    end
    tick();
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) dones++;
      if (busy) busys++;
    end
    check({tag, "_no_done"}, dones, 0);
    check({tag, "_no_busy"}, busys, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    alu_ctl  = 4'b0;
    a        = '0;
    b        = '0;
    last_res = '0;
`ifdef ALU_ABORT_EN
    abort    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_carry", {31'b0, carry_out}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);

    run_op("add", 4'b0010, 8'h7F, 8'h01, -1);
    check("add_const", {24'b0, result}, 32'h80);
    run_op("sub", 4'b0110, 8'h05, 8'h05, -1);
    check("sub_zero_const", {31'b0, zero}, 32'd1);
    run_op("slt_neg", 4'b0111, 8'h80, 8'h01, -1);
    check("slt_neg_const", {24'b0, result}, 32'h01);
    run_op("slt_ovf", 4'b0111, 8'h7F, 8'h80, -1);
    check("slt_ovf_const", {31'b0, overflow}, 32'd1);
    run_op("and", 4'b0000, 8'hF0, 8'h3C, -1);
    run_op("or", 4'b0001, 8'hF0, 8'h3C, -1);
    run_op("nor", 4'b1100, 8'hF0, 8'h3C, -1);
    check("nor_const", {24'b0, result}, 32'h03);

    run_op("restart", 4'b0010, 8'h12, 8'h34, 2);
    quiet("restart", 12);

    // Reset while bit 4 is being processed
    alu_ctl = 4'b0010;
    a       = 8'h21;
    b       = 8'h43;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_result", {24'b0, result}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    last_res = '0;
    quiet("midrst", 12);

`ifdef ALU_ABORT_EN
    run_op("preload", 4'b0001, 8'h55, 8'h00, -1);
    alu_ctl = 4'b0010;
    a       = 8'h10;
    b       = 8'h20;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    quiet("abort", 12);
    check("abort_result", {24'b0, result}, 32'h55);
    run_op("post_abort", 4'b0010, 8'h10, 8'h20, -1);
    check("post_abort_const", {24'b0, result}, 32'h30);
`endif

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
